// File: rtl/fifo_rd_packer.sv
// Read-side consumer of the async FIFO: packs PACK_RATIO fall-through entries into one wide
// valid/ready word, emitting partial words on flush or idle timeout with a per-lane keep mask.
module fifo_rd_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PACK_RATIO     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             rclk,
  input  logic                             rrst_n,
  input  logic [DATA_WIDTH-1:0]            fifo_rdata,
  input  logic                             fifo_rempty,
  output logic                             fifo_rinc,
  input  logic                             flush,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]            m_keep,
  output logic                             busy
);

  localparam int CW = $clog2(PACK_RATIO);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(PACK_RATIO - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);

  typedef logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lanes_t;

  lanes_t                acc_q, acc_d, acc_pop;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  m_valid_q, m_valid_d;
  lanes_t                m_data_q, m_data_d;
  logic [PACK_RATIO-1:0] m_keep_q, m_keep_d;

  logic out_free, timeout, emit_partial, pop, full_load;
  logic [PACK_RATIO-1:0] partial_keep;

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    out_free     = !m_valid_q || m_ready;
    timeout      = (TIMEOUT_CYCLES != 0) && (timer_q == TIMER_MAX);
    emit_partial = (flush_pend_q || timeout) && (cnt_q != '0) && out_free;
    // The pop strobe is gated by reset so the FIFO is never drained while we are held in reset.
    pop          = rrst_n && !fifo_rempty && ((cnt_q != LAST_LANE) || out_free) && !emit_partial;
    full_load    = pop && (cnt_q == LAST_LANE);

    acc_pop = acc_q;
    if (pop) acc_pop[cnt_q] = fifo_rdata;

    partial_keep = '0;
    for (int i = 0; i < PACK_RATIO; i++) partial_keep[i] = (i < int'(cnt_q));

    acc_d     = acc_pop;
    cnt_d     = pop ? cnt_q + CW'(1) : cnt_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_valid_d = m_valid_q && !m_ready;

    if (full_load || emit_partial) begin
      m_data_d  = acc_pop;
      m_keep_d  = full_load ? '1 : partial_keep;
      m_valid_d = 1'b1;
      // Clearing the accumulator keeps unused lanes of the next partial word at zero.
      acc_d     = '0;
      cnt_d     = '0;
    end

    timer_d = timer_q;
    if (pop || (cnt_q == '0) || emit_partial) timer_d = '0;
    else if (timer_q != TIMER_MAX)            timer_d = timer_q + TW'(1);

    flush_pend_d = flush_pend_q || flush;
    if (emit_partial || full_load || ((cnt_q == '0) && !pop)) flush_pend_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      flush_pend_q <= flush_pend_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
    end
  end

  assign fifo_rinc = pop;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_keep    = m_keep_q;
  assign busy      = (cnt_q != '0) || m_valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a queue models the FIFO read port, and accepted
// output words are collected and compared with hand-computed values.
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rrst_n;
  logic [7:0]  fifo_rdata = '0;
  logic        fifo_rempty = 1'b1;
  logic        fifo_rinc;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int pop_cnt = 0;
  int p0;
  int cycles;

  logic [7:0]  fifo_q[$];
  logic [31:0] out_data[$];
  logic [3:0]  out_keep[$];

  fifo_rd_packer #(.DATA_WIDTH(8), .PACK_RATIO(4), .TIMEOUT_CYCLES(16)) dut (
    .rclk(clk), .rrst_n(rrst_n), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
    .fifo_rinc(fifo_rinc), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO model: pop on the edge, present the new head well before the next edge.
  always @(posedge clk) begin
    if (fifo_rinc && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
  end

  always @(negedge clk) begin
    #2;
    fifo_rempty = (fifo_q.size() == 0);
    fifo_rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  always @(posedge clk) begin
    if (rrst_n && m_valid && m_ready) begin
      out_data.push_back(m_data);
      out_keep.push_back(m_keep);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fifo_q.push_back(v);
  endtask

  function automatic logic [31:0] word_at(input int i);
    return (out_data.size() > i) ? out_data[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [3:0] keep_at(input int i);
    return (out_keep.size() > i) ? out_keep[i] : 4'hx;
  endfunction

  task automatic clear_out();
    out_data.delete();
    out_keep.delete();
  endtask

  initial begin
    rrst_n  = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;

    // 1: reset state, then eight entries stream out as two full words, one pop per cycle
    for (int i = 1; i <= 8; i++) push(8'(i));
    @(negedge clk); #3;
    check("rst_rinc",  fifo_rinc, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data",  m_data, 0);
    check("rst_keep",  m_keep, 0);
    check("rst_busy",  busy, 0);
    @(negedge clk);
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    p0 = pop_cnt;
    repeat (8) begin
      #3 check("t1_rinc_each_cycle", fifo_rinc, 1);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("t1_pops",   pop_cnt - p0, 8);
    check("t1_nwords", out_data.size(), 2);
    check("t1_word0",  word_at(0), 32'h0403_0201);
    check("t1_word1",  word_at(1), 32'h0807_0605);
    check("t1_keep0",  keep_at(0), 4'hF);
    check("t1_keep1",  keep_at(1), 4'hF);
    check("t1_idle",   busy, 0);

    // 2: backpressure holds the word; three more lanes fill, then popping stops
    clear_out();
    m_ready = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    repeat (4) @(negedge clk);
    repeat (10) begin
      check("t2_valid_held", m_valid, 1);
      check("t2_data_held",  m_data, 32'h1312_1110);
      @(negedge clk);
    end
    #3;
    check("t2_rinc_stalled", fifo_rinc, 0);
    check("t2_pops",         pop_cnt - p0, 7);
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("t2_nwords", out_data.size(), 2);
    check("t2_word0",  word_at(0), 32'h1312_1110);
    check("t2_word1",  word_at(1), 32'h1716_1514);
    check("t2_keep1",  keep_at(1), 4'hF);

    // 3: two entries then idle; the timeout emits a partial word
    clear_out();
    m_ready = 1'b0;
    push(8'hAA);
    push(8'hBB);
    cycles = 0;
    while (!m_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check("t3_valid",   m_valid, 1);
    check("t3_latency", cycles, 19);
    check("t3_data",    m_data, 32'h0000_BBAA);
    check("t3_keep",    m_keep, 4'b0011);
    m_ready = 1'b1;
    @(negedge clk);
    check("t3_drained", m_valid, 0);

    // 4: flush while the output is stalled waits for the prior word to be accepted
    clear_out();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
    push(8'hCC);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_prior_valid", m_valid, 1);
    check("t4_prior_data",  m_data, 32'h2423_2221);
    check("t4_prior_keep",  m_keep, 4'hF);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("t4_part_valid", m_valid, 1);
    check("t4_part_data",  m_data, 32'h0000_00CC);
    check("t4_part_keep",  m_keep, 4'b0001);
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_nwords", out_data.size(), 2);
    check("t4_idle",   busy, 0);

    // 5: flush coincides with the 4th pop; one full word, no trailing empty word
    clear_out();
    for (int i = 1; i <= 4; i++) push(8'(i * 8'h11));
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (25) @(negedge clk);
    check("t5_nwords", out_data.size(), 1);
    check("t5_word",   word_at(0), 32'h4433_2211);
    check("t5_keep",   keep_at(0), 4'hF);
    check("t5_idle",   busy, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_empty_flush_nwords", out_data.size(), 1);
    check("t5_empty_flush_valid",  m_valid, 0);

    // 6: reset mid-word and mid-handshake discards everything at once
    clear_out();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h51 + 8'(i));
    repeat (8) @(negedge clk);
    check("t6_pre_valid", m_valid, 1);
    check("t6_pre_busy",  busy, 1);
    rrst_n = 1'b0;
    #1;
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_keep",  m_keep, 0);
    check("t6_rst_data",  m_data, 0);
    for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
    #2;
    check("t6_rst_rinc", fifo_rinc, 0);
    @(negedge clk);
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    clear_out();
    repeat (8) @(negedge clk);
    check("t6_nwords", out_data.size(), 1);
    check("t6_word",   word_at(0), 32'h6463_6261);
    check("t6_keep",   keep_at(0), 4'hF);
    check("t6_idle",   busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
